tbl_entry_loader: RTL and testbench

Control-plane writer that fills match-table entries into the BRAM port B that the matcher later reads.
- Takes one 128-bit entry plus a BRAM word address.
- Writes the entry as 4 consecutive 32-bit words, MSB word first.
- Optionally reads the words back and compares them.
- Replaces hand-driven port-B stimulus in benches and gives the future host/CPU path a single-request handshake.

---
 rtl/tbl_entry_loader_pkg.sv | 22 ++
 rtl/tbl_entry_loader.sv | 159 +++++++++++++++
 tb/tb_tbl_entry_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tbl_entry_loader_pkg.sv
// Shared constants and state encoding for the match-table entry loader.
// Imported by the loader top and any future host-side bridge.
package tbl_entry_loader_pkg;

  localparam int TBL_ENTRY_WORDS = 4;
  localparam int TBL_ADDR_W      = 10;
  localparam int TBL_DATA_W      = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [TBL_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WRITE,
    LD_READ,
    LD_CHECK,
    LD_DONE
  } ld_state_e;

endpackage

// File: rtl/tbl_entry_loader.sv
// Writes one match-table entry into BRAM port B, MSB word first,
// with optional readback compare and a sticky mismatch flag.
module tbl_entry_loader
  import tbl_entry_loader_pkg::*;
#(
  parameter int ENTRY_WORDS = TBL_ENTRY_WORDS,
  parameter int ADDR_W      = TBL_ADDR_W,
  parameter int DATA_W      = TBL_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [ADDR_W-1:0]             entry_addr_i,
  input  logic [DATA_W*ENTRY_WORDS-1:0] entry_data_i,
  input  logic                          verify_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o,
  output logic                          bram_enb_o,
  output logic                          bram_web_o,
  output logic [ADDR_W-1:0]             bram_addrb_o,
  output logic [DATA_W-1:0]             bram_dinb_o,
  input  logic [DATA_W-1:0]             bram_doutb_i
);

  localparam int ENTRY_W = DATA_W * ENTRY_WORDS;
  localparam int CNT_W   = $clog2(ENTRY_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ENTRY_WORDS - 1);

  // Word k sits at the top after shifting left by k words.
  function automatic logic [DATA_W-1:0] word_sel(
    input logic [ENTRY_W-1:0] d,
    input logic [CNT_W-1:0]   k
  );
    logic [ENTRY_W-1:0] sh;
    sh = d << (DATA_W * int'(k));
    return sh[ENTRY_W-1 -: DATA_W];
  endfunction

  ld_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ENTRY_W-1:0] data_q, data_d;
  logic               ver_q, ver_d;
  logic               err_q, err_d;
  logic               rd_v_q, rd_v_d;
  logic [CNT_W-1:0]   rd_idx_q, rd_idx_d;
  logic               enb_q, enb_d;
  logic               web_q, web_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               accept;
  logic               mismatch;

  assign accept = start_i &&
                  (state_q == LD_IDLE || state_q == LD_DONE);

  // Readback of word j arrives the cycle after its read was issued.
  assign mismatch = rd_v_q &&
                    (bram_doutb_i != word_sel(data_q, rd_idx_q));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    data_d   = data_q;
    ver_d    = ver_q;
    err_d    = err_q | mismatch;
    rd_v_d   = (state_q == LD_READ);
    rd_idx_d = cnt_q;

    unique case (state_q)
      LD_IDLE: ;
      LD_WRITE: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ver_q ? LD_READ : LD_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LD_READ: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = LD_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LD_CHECK: state_d = LD_DONE;
      LD_DONE:  state_d = LD_IDLE;
      default:  state_d = LD_IDLE;
    endcase

    if (accept) begin
      state_d = LD_WRITE;
      cnt_d   = '0;
      base_d  = entry_addr_i;
      data_d  = entry_data_i;
      ver_d   = verify_i;
      err_d   = FALSE;
    end

    enb_d  = FALSE;
    web_d  = FALSE;
    addr_d = '0;
    din_d  = ZERO_WORD;
    if (state_d == LD_WRITE) begin
      enb_d  = TRUE;
      web_d  = TRUE;
      addr_d = base_d + ADDR_W'(cnt_d);
      din_d  = word_sel(data_d, cnt_d);
    end else if (state_d == LD_READ) begin
      enb_d  = TRUE;
      addr_d = base_d + ADDR_W'(cnt_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LD_IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      data_q   <= '0;
      ver_q    <= FALSE;
      err_q    <= FALSE;
      rd_v_q   <= FALSE;
      rd_idx_q <= '0;
      enb_q    <= FALSE;
      web_q    <= FALSE;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      data_q   <= data_d;
      ver_q    <= ver_d;
      err_q    <= err_d;
      rd_v_q   <= rd_v_d;
      rd_idx_q <= rd_idx_d;
      enb_q    <= enb_d;
      web_q    <= web_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign busy_o = (state_q == LD_WRITE) ||
                  (state_q == LD_READ)  ||
                  (state_q == LD_CHECK);
  assign done_o       = (state_q == LD_DONE);
  assign error_o      = err_q;
  assign bram_enb_o   = enb_q;
  assign bram_web_o   = web_q;
  assign bram_addrb_o = addr_q;
  assign bram_dinb_o  = din_q;

endmodule

// File: tb/tb_tbl_entry_loader.sv
// Scoreboard bench for tbl_entry_loader: stimulus queues expected
// port-B accesses and done pulses, a negedge monitor checks them.
module tb_tbl_entry_loader;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic [9:0]   entry_addr_i;
  logic [127:0] entry_data_i;
  logic         verify_i;
  logic         busy_o, done_o, error_o;
  logic         bram_enb_o, bram_web_o;
  logic [9:0]   bram_addrb_o;
  logic [31:0]  bram_dinb_o;
  logic [31:0]  bram_doutb;

  tbl_entry_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .entry_addr_i (entry_addr_i),
    .entry_data_i (entry_data_i),
    .verify_i     (verify_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .bram_enb_o   (bram_enb_o),
    .bram_web_o   (bram_web_o),
    .bram_addrb_o (bram_addrb_o),
    .bram_dinb_o  (bram_dinb_o),
    .bram_doutb_i (bram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [9:0]  addr;
    logic        web;
    logic [31:0] din;
  } acc_t;

  typedef struct packed {
    int   cyc;
    logic err;
  } done_t;

  acc_t  acc_q[$];
  done_t done_q[$];
  acc_t  ea;
  done_t ed;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int bs = 1;
  int be = 0;

  logic [31:0] mem [0:1023];
  logic        corrupt_en;
  logic [9:0]  corrupt_addr;

  localparam logic [127:0] D1 = 128'hb7acf62c_deadbeef_face0001_00000000;
  localparam logic [127:0] D2 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D3 = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
  localparam logic [127:0] D4 = 128'hcafef00d_01234567_89abcdef_76543210;

  always @(posedge clk) cyc <= cyc + 1;

  // Port-B BRAM model: 1-cycle read latency, optional forced-zero read.
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bram_enb_o) begin
      if (bram_web_o)
        mem[bram_addrb_o] <= bram_dinb_o;
      else
        bram_doutb <= (corrupt_en && bram_addrb_o == corrupt_addr)
                      ? 32'h0 : mem[bram_addrb_o];
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, exp, $time);
    else
      passes++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy_o, (cyc >= bs && cyc <= be));
      if (bram_enb_o) begin
        if (acc_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_access: got addr %0h web %0b want none",
                   bram_addrb_o, bram_web_o);
        end else begin
          ea = acc_q.pop_front();
          chk("acc_cycle", cyc, ea.cyc);
          chk("acc_addr", bram_addrb_o, ea.addr);
          chk("acc_web", bram_web_o, ea.web);
          chk("acc_din", bram_dinb_o, ea.din);
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
        end else begin
          ed = done_q.pop_front();
          chk("done_cycle", cyc, ed.cyc);
          chk("done_error", error_o, ed.err);
        end
      end
    end
  end

  task automatic issue(input logic [9:0] a, input logic [127:0] d,
                       input logic v, input logic err);
    int   c0;
    acc_t t;
    done_t dn;
    c0 = cyc;
    start_i      = 1'b1;
    entry_addr_i = a;
    entry_data_i = d;
    verify_i     = v;
    for (int k = 0; k < 4; k++) begin
      t.cyc  = c0 + 1 + k;
      t.addr = a + 10'(k);
      t.web  = 1'b1;
      t.din  = d[127-32*k -: 32];
      acc_q.push_back(t);
    end
    if (v) begin
      for (int k = 0; k < 4; k++) begin
        t.cyc  = c0 + 5 + k;
        t.addr = a + 10'(k);
        t.web  = 1'b0;
        t.din  = 32'h0;
        acc_q.push_back(t);
      end
    end
    dn.cyc = c0 + (v ? 10 : 5);
    dn.err = err;
    done_q.push_back(dn);
    bs = c0 + 1;
    be = c0 + (v ? 9 : 4);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    start_i      = 1'b0;
    entry_addr_i = '0;
    entry_data_i = '0;
    verify_i     = 1'b0;
    corrupt_en   = 1'b0;
    corrupt_addr = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_enb", bram_enb_o, 0);
    chk("rst_web", bram_web_o, 0);
    chk("rst_addr", bram_addrb_o, 0);
    chk("rst_din", bram_dinb_o, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write with verify, clean readback.
    issue(10'h21c, D1, 1'b1, 1'b0);
    repeat (11) @(negedge clk);
    chk("mem_21c", mem[10'h21c], 32'hb7acf62c);
    chk("mem_21f", mem[10'h21f], 32'h00000000);

    // Address wrap past 3ff.
    issue(10'h3fe, D2, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    chk("wrap_3fe", mem[10'h3fe], 32'h11111111);
    chk("wrap_3ff", mem[10'h3ff], 32'h22222222);
    chk("wrap_000", mem[10'h000], 32'h33333333);
    chk("wrap_001", mem[10'h001], 32'h44444444);

    // Readback of word 2 forced to zero.
    corrupt_en   = 1'b1;
    corrupt_addr = 10'h082;
    issue(10'h080, D1, 1'b1, 1'b1);
    repeat (11) @(negedge clk);
    corrupt_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_held_idle", error_o, 1);

    // Start while busy is ignored; error clears on acceptance.
    issue(10'h21c, D3, 1'b0, 1'b0);
    chk("err_cleared", error_o, 0);
    @(negedge clk);
    @(negedge clk);
    start_i      = 1'b1;
    entry_addr_i = 10'h000;
    @(negedge clk);
    start_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_ign_000", mem[10'h000], 32'h33333333);

    // Asynchronous reset during cycle 2 of a write.
    issue(10'h200, D4, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    bs  = 1;
    be  = 0;
    rst = 1'b1;
    acc_q.delete();
    done_q.delete();
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_enb", bram_enb_o, 0);
    chk("mid_rst_web", bram_web_o, 0);
    chk("mid_rst_addr", bram_addrb_o, 0);
    chk("mid_rst_din", bram_dinb_o, 0);
    chk("mid_rst_done", done_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rst_w0", mem[10'h200], 32'hcafef00d);
    chk("mid_rst_w1", mem[10'h201], 32'h0);
    issue(10'h300, D2, 1'b1, 1'b0);
    repeat (11) @(negedge clk);

    // Back-to-back: second start in the DONE cycle of the first.
    issue(10'h0c0, D3, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("b2b_in_done", done_o, 1);
    issue(10'h100, D4, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    chk("b2b_mem_100", mem[10'h100], 32'hcafef00d);
    chk("b2b_mem_0c3", mem[10'h0c3], 32'hf0f0f0f0);

    repeat (4) @(negedge clk);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
